// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: issues one word-aligned read at a time and
// hands the returned {pc, instruction} pair to decode.
module inst_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 'h0000_1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_inst
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; once raised, if_valid and its payload hold until that transfer
    // or until a redirect drops them. redirect_valid outranks every handshake.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  flush_q, flush_d;
    logic                  if_valid_q, if_valid_d;
    logic [DATA_WIDTH-1:0] if_pc_q, if_pc_d;
    logic [DATA_WIDTH-1:0] if_inst_q, if_inst_d;

    logic [DATA_WIDTH-1:0] redirect_tgt;
    logic [DATA_WIDTH-1:0] req_pc_plus4;

    assign redirect_tgt = redirect_pc & ~DATA_WIDTH'(3);
    assign req_pc_plus4 = req_pc_q + DATA_WIDTH'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            flush_q    <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            flush_q    <= flush_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (!redirect_valid && imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) state_d = (flush_q || redirect_valid) ? S_REQ : S_OUT;
            end
            S_OUT: begin
                if (redirect_valid || if_ready) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        imem_req_addr  = fetch_pc_q;
        fetch_pc_d     = fetch_pc_q;
        req_pc_d       = req_pc_q;
        flush_d        = flush_q;
        if_valid_d     = if_valid_q;
        if_pc_d        = if_pc_q;
        if_inst_d      = if_inst_q;
        case (state_q)
            S_REQ: begin
                imem_req_valid = !redirect_valid;
                if (redirect_valid) begin
                    fetch_pc_d = redirect_tgt;
                end else if (imem_req_ready) begin
                    req_pc_d = fetch_pc_q;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_tgt;
                    flush_d    = 1'b1;
                end
                // A redirect seen at any point during the wait poisons the response.
                if (imem_rsp_valid) begin
                    if (flush_q || redirect_valid) begin
                        flush_d = 1'b0;
                    end else begin
                        if_valid_d = 1'b1;
                        if_pc_d    = req_pc_q;
                        if_inst_d  = imem_rsp_data;
                        fetch_pc_d = req_pc_plus4;
                    end
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    fetch_pc_d = redirect_tgt;
                end else if (if_ready) begin
                    if_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a latency-programmable memory model
// and scoreboards for request addresses and decode-side {pc, inst} pairs.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  inst_fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_1000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_q[$];
  int          acc_cyc_q[$];
  int          checks;
  int          errors;
  int          cyc;

  // memory model state
  bit          mem_ready_en;
  bit          use_nop;
  int          mem_lat;
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;

  function automatic logic [31:0] inst_of(input logic [31:0] a, input bit nop);
    return nop ? 32'h0000_0013 : (a ^ 32'hC0DE_0013);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at negedge, then drive the memory response.
  task automatic tick();
    logic [31:0] a;
    logic [63:0] e;
    @(negedge clk);
    imem_req_ready = mem_ready_en && (exp_addr_q.size() != 0);
    if (!rst && imem_req_valid && imem_req_ready) begin
      a = exp_addr_q.pop_front();
      chk("req_addr", {32'h0, imem_req_addr}, {32'h0, a});
      pend      = 1'b1;
      pend_addr = imem_req_addr;
      pend_cnt  = mem_lat;
      acc_cyc_q.push_back(cyc);
    end
    if (!rst && if_valid && if_ready && !redirect_valid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out: observed pc=%h inst=%h expected none", if_pc, if_inst);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks--;
        chk("if_pair", {if_pc, if_inst}, e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else if (pend) begin
      if (pend_cnt <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = inst_of(pend_addr, use_nop);
        pend           = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || exp_addr_q.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    assert (exp_q.size() == 0 && exp_addr_q.size() == 0) else begin
      errors++;
      $error("FAIL %s_timeout: observed %0d outputs and %0d requests pending expected 0",
             tag, exp_q.size(), exp_addr_q.size());
      exp_q.delete();
      exp_addr_q.delete();
    end
  endtask

  task automatic push_fetch(input logic [31:0] a);
    exp_addr_q.push_back(a);
    exp_q.push_back({a, inst_of(a, use_nop)});
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b0;
    mem_ready_en = 1'b1; use_nop = 1'b1; mem_lat = 1; pend = 1'b0; pend_cnt = 0; pend_addr = '0;

    // reset state
    repeat (3) tick();
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("rst_req_addr", {32'h0, imem_req_addr}, 64'h1000);
    chk("rst_if_valid", {63'h0, if_valid}, 64'h0);
    chk("rst_if_pc", {32'h0, if_pc}, 64'h0);
    chk("rst_if_inst", {32'h0, if_inst}, 64'h0);
    rst = 1'b0;
    #1;
    chk("idle_req_valid", {63'h0, imem_req_valid}, 64'h0);
    tick();
    chk("first_req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("first_req_addr", {32'h0, imem_req_addr}, 64'h1000);

    // sequential fetch, zero-wait memory, always-ready decode
    if_ready = 1'b1;
    acc_cyc_q.delete();
    push_fetch(32'h1000);
    push_fetch(32'h1004);
    push_fetch(32'h1008);
    drain("seq");
    if (acc_cyc_q.size() >= 3) begin
      chk("rate_0_1", 64'(acc_cyc_q[1] - acc_cyc_q[0]), 64'd3);
      chk("rate_1_2", 64'(acc_cyc_q[2] - acc_cyc_q[1]), 64'd3);
    end else begin
      chk("rate_accepts", 64'(acc_cyc_q.size()), 64'd3);
    end

    // decode stall for 5 cycles
    if_ready = 1'b0;
    push_fetch(32'h100C);
    for (int i = 0; i < 10 && !if_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_if_valid", {63'h0, if_valid}, 64'h1);
      chk("stall_if_pair", {if_pc, if_inst}, {32'h100C, 32'h0000_0013});
      chk("stall_req_valid", {63'h0, imem_req_valid}, 64'h0);
      tick();
    end
    if_ready = 1'b1;
    drain("stall");

    // redirect while waiting: in-flight response discarded
    use_nop = 1'b0;
    mem_lat = 3;
    exp_addr_q.push_back(32'h1010);
    tick();
    chk("wait_req_valid", {63'h0, imem_req_valid}, 64'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2002;
    tick();
    redirect_valid = 1'b0;
    chk("wait_redir_req_valid", {63'h0, imem_req_valid}, 64'h0);
    mem_lat = 1;
    push_fetch(32'h2000);
    drain("redir_wait");

    // redirect in the same cycle as the response
    exp_addr_q.push_back(32'h2004);
    tick();
    chk("same_cyc_rsp", {63'h0, imem_rsp_valid}, 64'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
    tick();
    redirect_valid = 1'b0;
    chk("same_cyc_if_valid", {63'h0, if_valid}, 64'h0);
    push_fetch(32'h3000);
    drain("redir_rsp");

    // redirect while an instruction is held, decode ready in the same cycle
    if_ready = 1'b0;
    exp_addr_q.push_back(32'h3004);
    tick();
    tick();
    chk("out_if_valid", {63'h0, if_valid}, 64'h1);
    chk("out_if_pair", {if_pc, if_inst}, {32'h3004, inst_of(32'h3004, 1'b0)});
    redirect_valid = 1'b1; redirect_pc = 32'h0000_4001; if_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("out_drop_if_valid", {63'h0, if_valid}, 64'h0);
    push_fetch(32'h4000);
    drain("redir_out");

    // wrap-around
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk("redir_req_valid", {63'h0, imem_req_valid}, 64'h0);
    tick();
    redirect_valid = 1'b0;
    chk("wrap_req_addr", {32'h0, imem_req_addr}, 64'hFFFF_FFFC);
    push_fetch(32'hFFFF_FFFC);
    push_fetch(32'h0000_0000);
    drain("wrap");

    // memory back-pressure, then reset while waiting
    mem_ready_en = 1'b0;
    exp_addr_q.push_back(32'h0000_0004);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_req_valid", {63'h0, imem_req_valid}, 64'h1);
      chk("bp_req_addr", {32'h0, imem_req_addr}, 64'h4);
    end
    mem_ready_en = 1'b1;
    mem_lat = 5;
    tick();
    chk("bp_wait_req_valid", {63'h0, imem_req_valid}, 64'h0);
    rst = 1'b1;
    #1;
    chk("mid_rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("mid_rst_req_addr", {32'h0, imem_req_addr}, 64'h1000);
    chk("mid_rst_if_valid", {63'h0, if_valid}, 64'h0);
    chk("mid_rst_if_pair", {if_pc, if_inst}, 64'h0);
    repeat (2) tick();
    rst = 1'b0;
    mem_lat = 1;
    tick();
    chk("restart_req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("restart_req_addr", {32'h0, imem_req_addr}, 64'h1000);
    push_fetch(32'h1000);
    drain("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
